// File: rtl/relock_scan_ctrl.sv
// Relock search controller: widens a scan window around the last known ramp
// centre until the loop reports lock, confirms the lock for lock_hold cycles,
// and gives up after max_retries full sweeps.
module relock_scan_ctrl #(
  parameter int R  = 14,
  parameter int TW = 8,
  parameter int LW = 10,
  parameter int NW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                relock_on,
  input  logic                out_of_lock,
  input  logic signed [R-1:0] ramp_A,
  input  logic                ramp_trigger_in,
  input  logic                reset,
  input  logic [R-2:0]        step_min,
  input  logic [R-2:0]        step_max,
  input  logic                grow_mode,
  input  logic [TW-1:0]       settle_len,
  input  logic [LW-1:0]       lock_hold,
  input  logic [NW-1:0]       max_retries,
  output logic signed [R-1:0] new_low_lim,
  output logic signed [R-1:0] new_hig_lim,
  output logic                run_ramp,
  output logic                freeze_pids,
  output logic [2:0]          state,
  output logic [NW-1:0]       retry_cnt,
  output logic                relock_fail,
  output logic                relock_ok
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SET_SIZE = 3'd1,
    SETTLE   = 3'd2,
    SCAN     = 3'd3,
    CONFIRM  = 3'd4,
    SUCCESS  = 3'd5,
    FAIL     = 3'd6,
    ILLEGAL  = 3'd7
  } st_e;

  localparam logic signed [R:0] SAT_MAX = {2'b00, {(R-1){1'b1}}};
  localparam logic signed [R:0] SAT_MIN = {2'b11, {(R-1){1'b0}}};

  st_e                st_q, st_d;
  logic [R-2:0]       size_q, size_d;
  logic signed [R-1:0] ctr_q, ctr_d;
  logic               first_q, first_d;
  logic [TW-1:0]      st_cnt_q, st_cnt_d;
  logic [LW-1:0]      lk_cnt_q, lk_cnt_d;
  logic [NW-1:0]      retry_q, retry_d;
  logic               trg_r1_q, trg_r2_q;
  logic               trig;

  logic [R-2:0]       eff_min, eff_max, size_grow;
  logic [R-1:0]       grow_w;
  logic signed [R:0]  lo_w, hi_w;

  // A zero step_min would stall the sweep, so the floor is 1; step_max never
  // drops below the effective minimum.
  assign eff_min = (step_min == '0) ? (R-1)'(1) : step_min;
  assign eff_max = (step_max > eff_min) ? step_max : eff_min;

  // Next half-span, formed one bit wider so doubling/adding cannot wrap.
  assign grow_w    = grow_mode ? ({1'b0, size_q} + {1'b0, eff_min}) : {size_q, 1'b0};
  assign size_grow = (grow_w > {1'b0, eff_max}) ? eff_max : grow_w[R-2:0];

  // End-of-scan marker: rising edge of the registered trigger input.
  assign trig = trg_r1_q & ~trg_r2_q;

  function automatic logic [R-1:0] sat(input logic signed [R:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[R-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[R-1:0];
    else                  sat = v[R-1:0];
  endfunction

  // Scan limits around the frozen centre, clamped to the signed R-bit range.
  always_comb begin
    lo_w        = {ctr_q[R-1], ctr_q} - $signed({2'b00, size_q});
    hi_w        = {ctr_q[R-1], ctr_q} + $signed({2'b00, size_q});
    new_low_lim = sat(lo_w);
    new_hig_lim = sat(hi_w);
  end

  // Next-state and datapath updates for the search sequence.
  always_comb begin
    st_d     = st_q;
    size_d   = size_q;
    ctr_d    = ctr_q;
    first_d  = first_q;
    st_cnt_d = st_cnt_q;
    lk_cnt_d = lk_cnt_q;
    retry_d  = retry_q;
    case (st_q)
      IDLE: begin
        ctr_d    = ramp_A;
        size_d   = eff_min;
        first_d  = 1'b1;
        st_cnt_d = '0;
        lk_cnt_d = '0;
        retry_d  = '0;
        if (relock_on && out_of_lock) st_d = SET_SIZE;
      end
      SET_SIZE: begin
        // The first pass of each sweep scans at the initial span unchanged.
        if (first_q) first_d = 1'b0;
        else         size_d  = size_grow;
        st_cnt_d = '0;
        st_d     = SETTLE;
      end
      SETTLE: begin
        if (st_cnt_q == settle_len) st_d = SCAN;
        else                        st_cnt_d = st_cnt_q + 1'b1;
      end
      SCAN: begin
        if (!out_of_lock) begin
          lk_cnt_d = '0;
          st_d     = CONFIRM;
        end else if (trig) begin
          if (size_q < eff_max) begin
            st_d = SET_SIZE;
          end else if (retry_q < max_retries) begin
            retry_d = retry_q + 1'b1;
            size_d  = eff_min;
            first_d = 1'b1;
            st_d    = SET_SIZE;
          end else begin
            st_d = FAIL;
          end
        end
      end
      CONFIRM: begin
        if (out_of_lock) begin
          lk_cnt_d = '0;
          st_d     = SCAN;
        end else if (lk_cnt_q == lock_hold) begin
          st_d = SUCCESS;
        end else begin
          lk_cnt_d = lk_cnt_q + 1'b1;
        end
      end
      SUCCESS: st_d = IDLE;
      FAIL:    if (reset || !relock_on) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    // Dropping relock_on aborts an active search immediately.
    if (!relock_on && (st_q inside {SET_SIZE, SETTLE, SCAN, CONFIRM})) st_d = IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      size_q   <= '0;
      ctr_q    <= '0;
      first_q  <= 1'b1;
      st_cnt_q <= '0;
      lk_cnt_q <= '0;
      retry_q  <= '0;
      trg_r1_q <= 1'b0;
      trg_r2_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      size_q   <= size_d;
      ctr_q    <= ctr_d;
      first_q  <= first_d;
      st_cnt_q <= st_cnt_d;
      lk_cnt_q <= lk_cnt_d;
      retry_q  <= retry_d;
      trg_r1_q <= ramp_trigger_in;
      trg_r2_q <= trg_r1_q;
    end
  end

  // Control outputs decoded straight from the state register.
  assign state       = st_q;
  assign retry_cnt   = retry_q;
  assign run_ramp    = st_q inside {SET_SIZE, SETTLE, SCAN};
  assign freeze_pids = st_q inside {SET_SIZE, SETTLE, SCAN, FAIL};
  assign relock_fail = (st_q == FAIL);
  assign relock_ok   = (st_q == SUCCESS);

endmodule

// File: doc/relock_scan_ctrl.md
RELOCK_SCAN_CTRL -- requirements
Module: relock_scan_ctrl

Interface
REQ-001 SHALL have parameter R, default 14: signal width of ramp_A and of the limits.
REQ-002 SHALL have parameter TW, default 8: width of the settle counter and of settle_len.
REQ-003 SHALL have parameter LW, default 10: width of the lock-confirm counter and of lock_hold.
REQ-004 SHALL have parameter NW, default 4: width of max_retries and retry_cnt.
REQ-005 SHALL have ports, one per line (name  direction  width  meaning):
 clk  in  1  single clock; all logic on its rising edge.
 rst  in  1  asynchronous, active-high reset.
 relock_on  in  1  enables the relock search.
 out_of_lock  in  1  high while the loop is unlocked.
 ramp_A  in  R  signed ramp centre value, tracked while in IDLE.
 ramp_trigger_in  in  1  ramp period marker; its rising edge marks the end of a scan.
 reset  in  1  clears FAIL.
 step_min  in  R-1  unsigned initial half-span.
 step_max  in  R-1  unsigned maximum half-span.
 grow_mode  in  1  0 = double the half-span, 1 = add step_min to it.
 settle_len  in  TW  settle cycles after each size change.
 lock_hold  in  LW  consecutive locked cycles needed to declare success.
 max_retries  in  NW  number of full-sweep restarts allowed before FAIL.
 new_low_lim, new_hig_lim  out  R  signed scan limits.
 run_ramp, freeze_pids  out  1  ramp-generator and PID controls.
 state  out  3  current state code.
 retry_cnt  out  NW  restarts used in the current search.
 relock_fail  out  1  high while in FAIL.
 relock_ok  out  1  one-cycle pulse on success.

Function
REQ-006 SHALL use these state codes: IDLE=0, SET_SIZE=1, SETTLE=2, SCAN=3, CONFIRM=4, SUCCESS=5, FAIL=6; code 7 SHALL go to IDLE on the next cycle.
REQ-007 SHALL register ramp_trigger_in once and generate trig as a one-cycle pulse on the registered rising edge (2-cycle latency from the input edge).
REQ-008 SHALL, in IDLE, each cycle: capture ramp_A into ctr, load size <= eff_min, set first = 1, clear the counters and retry_cnt; go to SET_SIZE when relock_on & out_of_lock.
REQ-009 SHALL use eff_min = max(step_min, 1) and eff_max = max(step_max, eff_min).
REQ-010 SHALL, in SET_SIZE (1 cycle) when first = 1: keep size and clear first.
REQ-011 SHALL, in SET_SIZE when first = 0: set size to min(size<<1, eff_max) if grow_mode = 0, or to min(size + eff_min, eff_max) if grow_mode = 1, computed at R bits without wrap; then go to SETTLE.
REQ-012 SHALL hold SETTLE for exactly settle_len+1 cycles (settle_len = 0 gives 1 cycle), then go to SCAN.
REQ-013 SHALL apply these SCAN priorities: out_of_lock = 0 goes to CONFIRM; else trig with size < eff_max goes to SET_SIZE; else trig with size = eff_max and retry_cnt < max_retries increments retry_cnt, sets size <= eff_min, first = 1, and goes to SET_SIZE; else trig goes to FAIL.
REQ-014 SHALL, in CONFIRM, count consecutive cycles with out_of_lock = 0 and go to SUCCESS when the count equals lock_hold (lock_hold = 0 gives SUCCESS the cycle after entry).
REQ-015 SHALL, in CONFIRM, clear the counter and return to SCAN when out_of_lock = 1; trig SHALL be ignored in CONFIRM.
REQ-016 SHALL hold SUCCESS for 1 cycle with relock_ok = 1, then go to IDLE.
REQ-017 SHALL leave FAIL for IDLE on reset = 1 or relock_on = 0.
REQ-018 SHALL go to IDLE from any state other than IDLE, FAIL and SUCCESS on relock_on = 0, with priority over all other transitions.
REQ-019 SHALL keep ctr frozen outside IDLE.
REQ-020 SHALL compute new_low_lim = sat(ctr - size) and new_hig_lim = sat(ctr + size) at R+1 bits, saturated to [-2^(R-1), 2^(R-1)-1], combinationally from registers.
REQ-021 SHALL drive run_ramp = 1 only in SET_SIZE, SETTLE and SCAN.
REQ-022 SHALL drive freeze_pids = 1 in SET_SIZE, SETTLE, SCAN and FAIL, and 0 in IDLE, CONFIRM and SUCCESS.
REQ-023 SHALL saturate retry_cnt; with max_retries = 0, the first trig at eff_max SHALL go to FAIL.

Reset
REQ-024 SHALL, on rst = 1 (asynchronous), force: state = IDLE, size = 0, ctr = 0, first = 1, counters = 0, retry_cnt = 0, trig register = 0; outputs run_ramp = 0, freeze_pids = 0, relock_fail = 0, relock_ok = 0, limits = 0/0.
REQ-025 SHALL abort an in-progress search on rst asserted in any state; after release the block SHALL restart from IDLE with no residual retry count.

Verification
REQ-026 SHALL cover doubling sweep: R=14, ramp_A=100, step_min=8, step_max=64, grow_mode=0, max_retries=0, out_of_lock held 1 -> limits 92/108, 84/116, 68/132, 36/164 on successive scans; FAIL on the 4th trig at eff_max; relock_fail = 1; run_ramp = 0.
REQ-027 SHALL cover additive sweep with retries: step_min=10, step_max=30, grow_mode=1, max_retries=2 -> sizes 10, 20, 30; then retry_cnt 1, 2 with the size back to 10 each time; FAIL after the third pass.
REQ-028 SHALL cover lock confirm: lock_hold=5; out_of_lock low 3 cycles in SCAN, then high -> back to SCAN; out_of_lock low 6 cycles -> SUCCESS, relock_ok pulse exactly 1 cycle, then IDLE.
REQ-029 SHALL cover saturation: ramp_A=8190, step_min=8 -> new_hig_lim = 8191, new_low_lim = 8182; ramp_A=-8190 -> new_low_lim = -8192.
REQ-030 SHALL cover aborts: relock_on dropped in SETTLE -> IDLE next cycle, freeze_pids = 0; rst pulsed in SCAN -> IDLE immediately, all outputs at reset values.
REQ-031 SHALL cover simultaneous events: out_of_lock falling in the same cycle as trig in SCAN -> CONFIRM, no size change.
